hazard_sched_unit: RTL and testbench

Pipeline hazard scheduler for the hazard-controlled 5-stage RISC-V core (IF/ID/EX/MEM/WB). Each cycle it decides PC and IF/ID write enables, ID/EX bubble insertion, per-stage flushes and EX-stage forwarding selects. Its inputs are decoded register fields, load/branch status and an instruction-memory wait signal. A small FSM enforces single-cycle load-use stalls and defers a taken-branch redirect that arrives during a fetch wait; saturating counters record stall and flush activity.

---
 rtl/hazard_sched_unit.sv | 137 +++++++++++++
 tb/tb_hazard_sched_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_sched_unit.sv
// Pipeline hazard scheduler: stall/flush/forwarding control for a 5-stage RISC-V core.
// Registered FSM handles load-use masking and fetch-wait redirect deferral.
module hazard_sched_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             mem_branch_taken,
  input  logic             imem_wait,
  output logic             pc_write,
  output logic             pc_sel_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLuStall   = 2'd1,
    StImemWait  = 2'd2,
    StRedirPend = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             uses_rs1, uses_rs2, lu_hz;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      7'b0000011, 7'b0010011: uses_rs1 = 1'b1;
      7'b0100011, 7'b1100011, 7'b0110011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign lu_hz = ex_mem_read && (ex_rd != 5'd0) &&
                 ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));

  // Priority: branch, fetch wait, deferred redirect, load-use, run.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    pc_sel_target = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    id_ex_bubble  = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    state_d       = StRun;
    if (mem_branch_taken) begin
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      flush_inc    = 1'b1;
      if (imem_wait) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        state_d     = StRedirPend;
      end else begin
        if_id_flush   = 1'b1;
        pc_sel_target = 1'b1;
      end
    end else if (imem_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      state_d      = (state_q == StRedirPend) ? StRedirPend : StImemWait;
    end else if (state_q == StRedirPend) begin
      if_id_flush   = 1'b1;
      pc_sel_target = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (lu_hz && (state_q != StLuStall)) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      state_d      = StLuStall;
    end
  end

  always_comb begin
    forward_a = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) begin
      forward_a = 2'b10;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
      forward_a = 2'b01;
    end
    forward_b = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) begin
      forward_b = 2'b10;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
      forward_b = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Directed bench for hazard_sched_unit with hand-computed expectations (CNT_W=4).
module tb_hazard_sched_unit;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic ex_mem_read, mem_reg_write, wb_reg_write, mem_branch_taken, imem_wait;
  logic pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic id_ex_bubble;
  logic [1:0] forward_a, forward_b, state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  hazard_sched_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .mem_branch_taken(mem_branch_taken), .imem_wait(imem_wait),
    .pc_write(pc_write), .pc_sel_target(pc_sel_target), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .id_ex_bubble(id_ex_bubble), .forward_a(forward_a), .forward_b(forward_b),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed control word: pc_write,if_id_write,pc_sel,if_id_fl,id_ex_fl,ex_mem_fl,bubble
  function automatic logic [6:0] ctl();
    return {pc_write, if_id_write, pc_sel_target, if_id_flush, id_ex_flush, ex_mem_flush,
            id_ex_bubble};
  endfunction

  task automatic idle();
    id_opcode = 7'b0010011; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    mem_reg_write = 1'b0; mem_rd = 5'd0; wb_reg_write = 1'b0; wb_rd = 5'd0;
    mem_branch_taken = 1'b0; imem_wait = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_stall", 16'(stall_cnt), 16'd0);
    chk("rst_flush", 16'(flush_cnt), 16'd0);
    chk("rst_ctl", 16'(ctl()), 16'b1100000);
    reset = 1'b1;
    step();

    // Load-use on rs2 of an R-type
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_opcode = 7'b0110011; id_rs1 = 5'd1; id_rs2 = 5'd5;
    #1 chk("lu_ctl", 16'(ctl()), 16'b0000001);
    step();
    chk("lu_state", 16'(state), 16'd1);
    chk("lu_mask_ctl", 16'(ctl()), 16'b1100000);
    chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
    step();
    chk("lu_back_run", 16'(state), 16'd0);
    idle();

    // No-stall cases: rd=x0, LUI consumer, I-type rs2 field ignored
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_opcode = 7'b0110011; id_rs1 = 5'd0;
    #1 chk("lu_x0", 16'(ctl()), 16'b1100000);
    ex_rd = 5'd5; id_opcode = 7'b0110111; id_rs1 = 5'd5; id_rs2 = 5'd5;
    #1 chk("lu_lui", 16'(ctl()), 16'b1100000);
    id_opcode = 7'b0010011; id_rs1 = 5'd3; id_rs2 = 5'd5;
    #1 chk("lu_itype_rs2", 16'(ctl()), 16'b1100000);
    step();
    chk("no_stall_cnt", 16'(stall_cnt), 16'd1);

    // Branch taken with simultaneous load-use: branch wins
    id_rs1 = 5'd5; mem_branch_taken = 1'b1;
    #1 chk("br_ctl", 16'(ctl()), 16'b1111110);
    step();
    chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br_stall_cnt", 16'(stall_cnt), 16'd1);
    chk("br_state", 16'(state), 16'd0);
    idle();

    // 3-cycle fetch wait with branch in cycle 2, then deferred redirect
    imem_wait = 1'b1;
    #1 chk("w1_ctl", 16'(ctl()), 16'b0000001);
    step();
    chk("w1_state", 16'(state), 16'd2);
    mem_branch_taken = 1'b1;
    #1 chk("w2_ctl", 16'(ctl()), 16'b0000110);
    step();
    chk("w2_state", 16'(state), 16'd3);
    mem_branch_taken = 1'b0;
    #1 chk("w3_ctl", 16'(ctl()), 16'b0000001);
    step();
    chk("w3_state", 16'(state), 16'd3);
    imem_wait = 1'b0;
    #1 chk("redir_ctl", 16'(ctl()), 16'b1111001);
    step();
    chk("redir_state", 16'(state), 16'd0);
    chk("wait_stall_cnt", 16'(stall_cnt), 16'd3);
    chk("wait_flush_cnt", 16'(flush_cnt), 16'd2);

    // Second branch while redirect pending
    imem_wait = 1'b1; mem_branch_taken = 1'b1;
    step();
    step();
    chk("br2_state", 16'(state), 16'd3);
    chk("br2_flush_cnt", 16'(flush_cnt), 16'd4);
    chk("br2_stall_cnt", 16'(stall_cnt), 16'd3);
    idle();
    step();
    chk("br2_release", 16'(state), 16'd0);

    // Forwarding priority
    mem_reg_write = 1'b1; mem_rd = 5'd7; wb_reg_write = 1'b1; wb_rd = 5'd7; ex_rs1 = 5'd7;
    ex_rs2 = 5'd9;
    #1 chk("fa_mem", 16'(forward_a), 16'b10);
    chk("fb_none", 16'(forward_b), 16'b00);
    mem_reg_write = 1'b0;
    #1 chk("fa_wb", 16'(forward_a), 16'b01);
    wb_rd = 5'd0;
    #1 chk("fa_x0", 16'(forward_a), 16'b00);
    mem_reg_write = 1'b1; mem_rd = 5'd9; wb_rd = 5'd9; ex_rs2 = 5'd9;
    #1 chk("fb_mem", 16'(forward_b), 16'b10);
    mem_rd = 5'd0;
    #1 chk("fb_wb", 16'(forward_b), 16'b01);
    idle();

    // Saturation: 3 + 16 wait cycles clamps at 15
    imem_wait = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("sat_reach", 16'(stall_cnt), 16'd15);
    for (int i = 0; i < 4; i++) step();
    chk("sat_hold", 16'(stall_cnt), 16'd15);

    // Reset in REDIR_PEND discards redirect
    mem_branch_taken = 1'b1;
    step();
    chk("pre_rst_state", 16'(state), 16'd3);
    mem_branch_taken = 1'b0; imem_wait = 1'b0;
    #2 reset = 1'b0;
    #1 chk("arst_state", 16'(state), 16'd0);
    chk("arst_stall", 16'(stall_cnt), 16'd0);
    chk("arst_flush", 16'(flush_cnt), 16'd0);
    chk("arst_ctl", 16'(ctl()), 16'b1100000);
    step();
    reset = 1'b1;
    #1 chk("post_rst_ctl", 16'(ctl()), 16'b1100000);
    step();
    chk("post_rst_state", 16'(state), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
